// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, opcodes and controller states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Opcode occupies the top three bits of every instruction word.
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC_RD = 3'd2,
    ST_EXEC_WR = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Accumulator ALU: ADD (carry dropped), AND, XOR, and LDA pass-through of the memory operand.
// Latency: combinational.
// Backpressure: none.
// Ports: op (opcode), acc (accumulator), m (memory operand), result.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = m;
    case (op)
      OP_ADD:  result = acc + m;
      OP_AND:  result = acc & m;
      OP_XOR:  result = acc ^ m;
      default: result = m;
    endcase
  end

endmodule

// File: rtl/risc_cpu_core.sv
// Accumulator CPU core with PC/IR/ACC and a fetch/decode/execute controller on a req/ack memory port.
// Latency: zero-wait HLT/SKZ/JMP 2 cycles, ADD/AND/XOR/LDA/STO 3 cycles; each memory wait cycle adds 1.
// Backpressure: a request holds req/we/addr/wdata stable until mem_ack; ack with no request is ignored.
// Ports: clk, rst (sync, active-high), start (restart from HALTED); mem_req/mem_we/mem_addr/mem_wdata
//        out, mem_rdata/mem_ack in; halted, retire (1-cycle per instruction), pc_dbg, acc_dbg.
module risc_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg
);

  if (DATA_W < 3 + ADDR_W) begin : g_bad_width
    $error("risc_cpu_core: DATA_W must be at least 3 + ADDR_W");
  end

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        opcode;
  logic              unused_ir;

  assign pc_inc    = pc + ADDR_W'(1);
  assign opcode    = ir[DATA_W-1 -: 3];
  assign operand   = ir[ADDR_W-1:0];
  // Bits between opcode and operand carry no meaning.
  assign unused_ir = ^ir;
  assign pc_dbg    = pc;
  assign acc_dbg   = acc;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .acc    (acc),
    .m      (mem_rdata),
    .result (alu_result)
  );

  // Requests are registered: every transition into a requesting state loads
  // req/we/addr/wdata on the same edge, so the request is live in the state's
  // first cycle and zero-wait memory can ack it immediately. Only the very
  // first FETCH after reset arrives with mem_req low and issues it itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_HLT: begin
              retire <= 1'b1;
              halted <= 1'b1;
              state  <= ST_HALTED;
            end
            OP_SKZ: begin
              // Zero test looks at ACC as it stands before this instruction.
              retire  <= 1'b1;
              state   <= ST_FETCH;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              if (acc == '0) begin
                pc       <= pc_inc;
                mem_addr <= pc_inc;
              end else begin
                mem_addr <= pc;
              end
            end
            OP_JMP: begin
              retire   <= 1'b1;
              pc       <= operand;
              state    <= ST_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= operand;
            end
            OP_STO: begin
              state     <= ST_EXEC_WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= operand;
              mem_wdata <= acc;
            end
            default: begin
              state    <= ST_EXEC_RD;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= operand;
            end
          endcase
        end
        ST_EXEC_RD, ST_EXEC_WR: begin
          if (mem_ack) begin
            if (state == ST_EXEC_RD) acc <= alu_result;
            retire   <= 1'b1;
            state    <= ST_FETCH;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        ST_HALTED: begin
          if (start) begin
            halted   <= 1'b0;
            state    <= ST_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_cpu_core.sv
// Bench for risc_cpu_core: unified memory with 0..3 cycle ack delay and an ISA-level reference model.
// Latency: n/a.
// Backpressure: memory model stretches requests with wait states.
module tb_risc_cpu_core;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int MEMSZ = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_req, mem_we, mem_ack, halted, retire;
  logic [AW-1:0] mem_addr, pc_dbg;
  logic [DW-1:0] mem_wdata, mem_rdata, acc_dbg;

  always #5 clk = ~clk;

  risc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .retire(retire), .pc_dbg(pc_dbg), .acc_dbg(acc_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents, program image and reference-model copy.
  logic [DW-1:0] mem   [MEMSZ];
  logic [DW-1:0] prog  [MEMSZ];
  logic [DW-1:0] m_mem [MEMSZ];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  // Request log entries: {we, addr, wdata (0 for reads)}.
  logic [13:0]   exp_q [$];
  logic [13:0]   obs_q [$];

  int   delay_mode = 0;   // <0: random 0..3 per request
  bit   ack_noise = 1'b0; // random ack while idle
  int   cur_delay, wait_cnt, total_waits;
  bit   req_active = 1'b0, ack_was = 1'b0;
  logic [13:0] snap;

  function automatic logic [7:0] ins(input int op, input int a);
    return 8'((op << 5) | (a & 31));
  endfunction

  function automatic logic [13:0] peek(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 14'h3fff;
  endfunction

  initial mem_ack = 1'b0;
  initial mem_rdata = '0;

  // Memory model: all activity on the falling edge, away from the DUT edge.
  always @(negedge clk) begin
    if (ack_was) req_active = 1'b0;
    ack_was = 1'b0;
    if (mem_req === 1'b1) begin
      if (!req_active) begin
        req_active = 1'b1;
        wait_cnt = 0;
        cur_delay = (delay_mode < 0) ? int'($urandom_range(3, 0)) : delay_mode;
        snap = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
      end else begin
        chk("req_stable", 32'({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}), 32'(snap));
      end
      if (wait_cnt >= cur_delay) begin
        mem_ack = 1'b1;
        ack_was = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem[mem_addr];
        obs_q.push_back(snap);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
        total_waits++;
        mem_rdata = 8'($urandom);
      end
    end else begin
      req_active = 1'b0;
      mem_ack = ack_noise ? 1'($urandom) : 1'b0;
      mem_rdata = 8'($urandom);
    end
  end

  // ISA-level reference: executes one instruction, returns its zero-wait cycle cost.
  task automatic model_step(output int cyc, output bit hlt);
    logic [7:0] w;
    logic [4:0] a;
    int op;
    w = m_mem[m_pc];
    exp_q.push_back({1'b0, m_pc, 8'h00});
    m_pc = m_pc + 5'd1;
    op = int'(w[7:5]);
    a = w[4:0];
    hlt = 1'b0;
    cyc = 3;
    case (op)
      0: begin hlt = 1'b1; cyc = 2; end
      1: begin if (m_acc == 8'h00) m_pc = m_pc + 5'd1; cyc = 2; end
      7: begin m_pc = a; cyc = 2; end
      6: begin exp_q.push_back({1'b1, a, m_acc}); m_mem[a] = m_acc; end
      default: begin
        exp_q.push_back({1'b0, a, 8'h00});
        case (op)
          2: m_acc = m_acc + m_mem[a];
          3: m_acc = m_acc & m_mem[a];
          4: m_acc = m_acc ^ m_mem[a];
          default: m_acc = m_mem[a];
        endcase
      end
    endcase
  endtask

  task automatic clear_prog();
    for (int i = 0; i < MEMSZ; i++) prog[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i] = prog[i];
      m_mem[i] = prog[i];
    end
    m_pc = '0;
    m_acc = '0;
    exp_q.delete();
    obs_q.delete();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc", 32'(pc_dbg), 32'd0);
    chk("rst_acc", 32'(acc_dbg), 32'd0);
    rst = 1'b0;
    total_waits = 0;
  endtask

  // Runs until HLT retires or max_instr instructions retire; checks state after every retire.
  task automatic run_prog(input int max_instr, input bit start_noise,
                          output int cyc, output int nret, output bit did_halt);
    int base = 0;
    int c;
    bit h;
    bit done = 1'b0;
    cyc = 0;
    nret = 0;
    did_halt = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (start_noise && !halted) ? 1'($urandom) : 1'b0;
      if (retire) begin
        model_step(c, h);
        base += c;
        nret++;
        chk("retire_pc", 32'(pc_dbg), 32'(m_pc));
        chk("retire_acc", 32'(acc_dbg), 32'(m_acc));
        chk("retire_halted", 32'(halted), 32'(h));
        if (h) begin
          did_halt = 1'b1;
          done = 1'b1;
          chk("cycles", 32'(cyc), 32'(base + total_waits + 1));
        end else if (nret >= max_instr) begin
          done = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (!done) chk("run_timeout", 32'd0, 32'd1);
    chk("req_count", 32'(obs_q.size() >= exp_q.size()), 32'd1);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("req_seq", 32'(obs_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < MEMSZ; i++)
      chk("mem_final", 32'(mem[i]), 32'(m_mem[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nret, k, idx;
    bit hl;

    // 1: zero-wait LDA/ADD/STO/HLT
    clear_prog();
    prog[0] = ins(5, 10); prog[1] = ins(2, 11); prog[2] = ins(6, 12); prog[3] = ins(0, 0);
    prog[10] = 8'd5; prog[11] = 8'd7;
    delay_mode = 0; ack_noise = 1'b0;
    do_reset();
    run_prog(50, 1'b1, cyc, nret, hl);
    chk("t1_halt", 32'(hl), 32'd1);
    chk("t1_retires", 32'(nret), 32'd4);
    chk("t1_cycles", 32'(cyc - 1), 32'd11);
    chk("t1_mem12", 32'(mem[12]), 32'd12);
    chk("t1_acc", 32'(acc_dbg), 32'd12);

    // 2: same program, three wait states per request, ack noise while idle
    delay_mode = 3; ack_noise = 1'b1;
    do_reset();
    run_prog(50, 1'b1, cyc, nret, hl);
    chk("t2_retires", 32'(nret), 32'd4);
    chk("t2_mem12", 32'(mem[12]), 32'd12);
    chk("t2_cycles", 32'(cyc - 1), 32'(11 + 7 * 3));

    // 3: SKZ taken with ACC=0, not taken with ACC=1, JMP 20
    clear_prog();
    prog[0] = ins(1, 0); prog[1] = ins(7, 20); prog[2] = ins(5, 10);
    prog[3] = ins(1, 0); prog[4] = ins(7, 20); prog[10] = 8'd1; prog[20] = ins(0, 0);
    delay_mode = -1;
    do_reset();
    run_prog(50, 1'b0, cyc, nret, hl);
    chk("t3_retires", 32'(nret), 32'd5);
    chk("t3_skip", 32'(peek(1)), 32'({1'b0, 5'd2, 8'h00}));
    chk("t3_jmp", 32'(peek(5)), 32'({1'b0, 5'd20, 8'h00}));
    chk("t3_pc", 32'(pc_dbg), 32'd21);

    // 4: SKZ at the last address wraps twice; ADD carry dropped
    clear_prog();
    prog[0] = ins(7, 31); prog[31] = ins(1, 0); prog[1] = ins(5, 10);
    prog[2] = ins(2, 11); prog[3] = ins(0, 0); prog[10] = 8'hFF; prog[11] = 8'h02;
    delay_mode = 0;
    do_reset();
    run_prog(50, 1'b0, cyc, nret, hl);
    chk("t4_wrap", 32'(peek(2)), 32'({1'b0, 5'd1, 8'h00}));
    chk("t4_acc", 32'(acc_dbg), 32'h01);

    // 5: HLT at 3, restart continues at 4; start while running is ignored
    clear_prog();
    prog[0] = ins(5, 10); prog[1] = ins(4, 11); prog[2] = ins(6, 12); prog[3] = ins(0, 0);
    prog[4] = ins(3, 13); prog[5] = ins(0, 0);
    prog[10] = 8'h3C; prog[11] = 8'h0F; prog[13] = 8'hF0;
    delay_mode = -1; ack_noise = 1'b1;
    do_reset();
    run_prog(50, 1'b1, cyc, nret, hl);
    chk("t5_pc_halt", 32'(pc_dbg), 32'd4);
    idx = obs_q.size();
    repeat (3) @(negedge clk);
    chk("t5_still_halted", 32'(halted), 32'd1);
    chk("t5_no_req", 32'(obs_q.size()), 32'(idx));
    start = 1'b1;
    total_waits = 0;
    run_prog(50, 1'b0, cyc, nret, hl);
    chk("t5_restart_fetch", 32'(peek(idx)), 32'({1'b0, 5'd4, 8'h00}));
    chk("t5_acc", 32'(acc_dbg), 32'h30);
    chk("t5_mem12", 32'(mem[12]), 32'h33);

    // 6: reset while EXEC_RD waits for ack
    clear_prog();
    prog[0] = ins(5, 10); prog[1] = ins(0, 0); prog[10] = 8'h55;
    delay_mode = 3;
    do_reset();
    k = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 5'd10) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_exec", 32'(k < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_pc", 32'(pc_dbg), 32'd0);
    chk("t6_acc", 32'(acc_dbg), 32'd0);
    obs_q.delete();
    rst = 1'b0;
    k = 0;
    while (obs_q.size() == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_refetch", 32'(peek(0)), 32'({1'b0, 5'd0, 8'h00}));

    // Random programs against the reference model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MEMSZ; i++) prog[i] = 8'($urandom);
      delay_mode = (r % 2 == 1) ? -1 : int'($urandom_range(3, 0));
      ack_noise = 1'($urandom);
      do_reset();
      run_prog(30, 1'b1, cyc, nret, hl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
